// File: rtl/axis_frame_vip.sv
// AXI-Stream video frame generator (4 patterns) plus an optional slave-side frame checker (AXIS_FRAME_VIP_CHECKER_EN).
// First beat one cycle after RUN is entered; a stalled beat (valid && !ready) holds data/last/user until accepted.
module axis_frame_vip #(
  parameter int DATA_BYTES = 1,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48,
  parameter int NUM_FRAMES = 1,
  parameter int FRAME_GAP  = 4,
  localparam int DATA_BITS = 8 * DATA_BYTES
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [DATA_BITS-1:0] const_i,
  output logic [DATA_BITS-1:0] axis_m_data_o,
  output logic                 axis_m_valid_o,
  input  logic                 axis_m_ready_i,
  output logic                 axis_m_last_o,
  output logic                 axis_m_user_o,
  input  logic [DATA_BITS-1:0] axis_s_data_i,
  input  logic                 axis_s_valid_i,
  output logic                 axis_s_ready_o,
  input  logic                 axis_s_last_i,
  input  logic                 axis_s_user_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          frame_cnt_o,
  output logic [15:0]          frames_rx_o,
  output logic                 err_last_o,
  output logic                 err_user_o
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  valid_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [15:0]           frame_cnt_q;
  logic [31:0]           run_frames_q;
  logic [15:0]           gap_q;
  logic [1:0]            mode_q;
  logic [DATA_BITS-1:0]  const_q;
  logic [DATA_BITS-1:0]  pix;

  logic start_ok, beat, eol, eof, frame_end, run_over, tile;

  assign start_ok  = start_i && (state_q == S_IDLE || state_q == S_DONE);
  assign beat      = valid_q && axis_m_ready_i;
  assign eol       = (x_q == X_LAST);
  assign eof       = eol && (y_q == Y_LAST);
  assign frame_end = beat && eof;
  // run_frames_q counts completed frames, so the frame now ending is the last one when it equals NUM_FRAMES-1
  assign run_over  = (NUM_FRAMES != 0) && (run_frames_q == 32'(NUM_FRAMES - 1));
  assign tile      = |(((32'(x_q) >> 3) ^ (32'(y_q) >> 3)) & 32'd1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (frame_end) begin
          if (run_over)            state_d = S_DONE;
          else if (FRAME_GAP == 0) state_d = S_RUN;
          else                     state_d = S_GAP;
        end
      end
      S_GAP:   if (gap_q == '0) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_cnt_q  <= '0;
      run_frames_q <= '0;
      gap_q        <= '0;
      mode_q       <= '0;
      const_q      <= '0;
    end else if (start_ok) begin
      valid_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_cnt_q  <= '0;
      run_frames_q <= '0;
      mode_q       <= mode_i;
      const_q      <= const_i;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (beat) begin
            x_q <= eol ? '0 : x_q + 1'b1;
            if (eol) y_q <= eof ? '0 : y_q + 1'b1;
            if (eof) begin
              frame_cnt_q  <= frame_cnt_q + 16'd1;
              run_frames_q <= run_frames_q + 32'd1;
              // gap of zero keeps valid high so the next frame follows without a bubble
              valid_q      <= (FRAME_GAP == 0) && !run_over;
              gap_q        <= 16'(FRAME_GAP - 1);
            end
          end
        end
        S_GAP: begin
          // raise valid on the RUN transition so the gap is exactly FRAME_GAP cycles
          if (gap_q == '0) valid_q <= 1'b1;
          else             gap_q   <= gap_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pix = '0;
    case (mode_q)
      2'd0:    pix = DATA_BITS'(x_q) + DATA_BITS'(y_q) + DATA_BITS'(frame_cnt_q);
      2'd1:    pix = tile ? '1 : '0;
      2'd2:    pix = const_q;
      default: pix = DATA_BITS'(frame_cnt_q);
    endcase
  end

  assign axis_m_valid_o = valid_q;
  assign axis_m_data_o  = valid_q ? pix : '0;
  assign axis_m_last_o  = valid_q && eol;
  assign axis_m_user_o  = valid_q && (x_q == '0) && (y_q == '0);
  assign busy_o         = (state_q == S_RUN) || (state_q == S_GAP);
  assign done_o         = (state_q == S_DONE);
  assign frame_cnt_o    = frame_cnt_q;
  assign axis_s_ready_o = rstn_i;

`ifdef AXIS_FRAME_VIP_CHECKER_EN
  logic [XW-1:0] rx_x_q;
  logic [YW-1:0] rx_y_q;
  logic [15:0]   frames_rx_q;
  logic          err_last_q, err_user_q;
  logic          s_beat, rx_eol;
  logic          unused_s;

  assign s_beat   = axis_s_valid_i && axis_s_ready_o;
  assign rx_eol   = (rx_x_q == X_LAST);
  assign unused_s = ^axis_s_data_i;

  // position is tracked by beat count, so a misplaced last does not resynchronise the checker
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_x_q      <= '0;
      rx_y_q      <= '0;
      frames_rx_q <= '0;
      err_last_q  <= 1'b0;
      err_user_q  <= 1'b0;
    end else if (start_ok) begin
      rx_x_q      <= '0;
      rx_y_q      <= '0;
      frames_rx_q <= '0;
      err_last_q  <= 1'b0;
      err_user_q  <= 1'b0;
    end else if (s_beat) begin
      if (axis_s_last_i != rx_eol) err_last_q <= 1'b1;
      if (axis_s_user_i != ((rx_x_q == '0) && (rx_y_q == '0))) err_user_q <= 1'b1;
      if (axis_s_last_i && (rx_y_q == Y_LAST)) frames_rx_q <= frames_rx_q + 16'd1;
      rx_x_q <= rx_eol ? '0 : rx_x_q + 1'b1;
      if (rx_eol) rx_y_q <= (rx_y_q == Y_LAST) ? '0 : rx_y_q + 1'b1;
    end
  end

  assign frames_rx_o = frames_rx_q;
  assign err_last_o  = err_last_q;
  assign err_user_o  = err_user_q;
`else
  logic unused_s;
  assign unused_s    = ^{axis_s_data_i, axis_s_valid_i, axis_s_last_i, axis_s_user_i};
  assign frames_rx_o = '0;
  assign err_last_o  = 1'b0;
  assign err_user_o  = 1'b0;
`endif

endmodule
